// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

  localparam int IDX_W_DEF = 10;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [2:0] {
    NONE,
    IF,
    DM,
    ERR_IF,
    ERR_DM
  } owner_t;

  // Word aligned and inside the memory's index range.
  function automatic logic addr_ok(input logic [31:0] addr, input int idx_w);
    return (addr[1:0] == 2'b00) && ((addr >> (idx_w + 2)) == 32'd0);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the fetch stage, data stage, arbiter and memory macro.
interface mem_port_arbiter_if #(
  parameter int IDX_W = mem_arb_pkg::IDX_W_DEF,
  parameter int CNT_W = 16
);
  logic             if_req;
  logic [31:0]      if_addr;
  logic             if_gnt;
  logic             if_rvalid;
  logic [31:0]      if_rdata;
  logic             dm_req;
  logic             dm_we;
  logic [31:0]      dm_addr;
  logic [31:0]      dm_wdata;
  logic             dm_gnt;
  logic             dm_rvalid;
  logic [31:0]      dm_rdata;
  logic             dm_err;
  logic             mem_en;
  logic             mem_we;
  logic [IDX_W-1:0] mem_idx;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;
  logic [CNT_W-1:0] if_stall_cnt;

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata, dm_err,
           mem_en, mem_we, mem_idx, mem_wdata, if_stall_cnt
  );

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata, dm_err,
           mem_en, mem_we, mem_idx, mem_wdata, if_stall_cnt
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one sync-read memory between IF and DM: DM-priority with IF starvation guard.
// Grant is same-cycle combinational, read data returns one cycle later; ungranted requesters hold.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int IDX_W    = IDX_W_DEF,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int SW = $clog2(MAX_WAIT + 1);
  localparam logic [SW-1:0] WAIT_LIM = SW'(MAX_WAIT);

  logic [SW-1:0]    starve_cnt;
  logic [CNT_W-1:0] stall_cnt;
  owner_t           owner;
  owner_t           owner_nxt;
  logic             starved;
  logic             if_gnt;
  logic             dm_gnt;
  logic             if_ok;
  logic             dm_ok;
  logic             mem_en;
  logic             mem_we;
  logic [IDX_W-1:0] mem_idx;

  assign starved = (starve_cnt == WAIT_LIM);
  assign if_gnt  = !rst && bus.if_req && (!bus.dm_req || starved);
  assign dm_gnt  = !rst && bus.dm_req && !(bus.if_req && starved);
  assign if_ok   = addr_ok(bus.if_addr, IDX_W);
  assign dm_ok   = addr_ok(bus.dm_addr, IDX_W);

  // Illegal accesses are still granted but never reach the memory.
  always_comb begin
    owner_nxt = NONE;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_idx   = '0;
    if (dm_gnt) begin
      if (dm_ok) begin
        mem_en    = 1'b1;
        mem_we    = bus.dm_we;
        mem_idx   = bus.dm_addr[IDX_W+1:2];
        owner_nxt = bus.dm_we ? NONE : DM;
      end else begin
        owner_nxt = ERR_DM;
      end
    end else if (if_gnt) begin
      if (if_ok) begin
        mem_en    = 1'b1;
        mem_idx   = bus.if_addr[IDX_W+1:2];
        owner_nxt = IF;
      end else begin
        owner_nxt = ERR_IF;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner      <= NONE;
      starve_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      owner <= owner_nxt;
      if (!bus.if_req || if_gnt) begin
        starve_cnt <= '0;
      end else if (!starved) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
      if (bus.if_req && !if_gnt && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

  assign bus.if_gnt       = if_gnt;
  assign bus.dm_gnt       = dm_gnt;
  assign bus.mem_en       = mem_en;
  assign bus.mem_we       = mem_we;
  assign bus.mem_idx      = mem_idx;
  assign bus.mem_wdata    = bus.dm_wdata;
  assign bus.if_stall_cnt = stall_cnt;

  // Return path is a decode of the registered tag; memory data is steered, never re-registered.
  assign bus.if_rvalid = (owner == IF) || (owner == ERR_IF);
  assign bus.if_rdata  = (owner == IF) ? bus.mem_rdata : NOP_WORD;
  assign bus.dm_rvalid = (owner == DM) || (owner == ERR_DM);
  assign bus.dm_err    = (owner == ERR_DM);
  assign bus.dm_rdata  = (owner == DM) ? bus.mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a per-cycle reference model of grants and returns.
module tb_mem_port_arbiter;

  localparam int IDX_W    = 10;
  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 16;
  localparam int DEPTH    = 1 << IDX_W;

  logic clk;
  logic rst;
  int   nvec;
  int   nerr;

  mem_port_arbiter_if #(.IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

  mem_port_arbiter #(.IDX_W(IDX_W), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory macro: synchronous read, one access per cycle, reloaded while in reset.
  logic [31:0] mem [DEPTH];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h1000_0000 + i;
      bus.mem_rdata <= 32'h0;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_idx] <= bus.mem_wdata;
      else            bus.mem_rdata    <= mem[bus.mem_idx];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [31:0] a);
    return (a % 4 == 0) && (a < (32'd4 << IDX_W));
  endfunction

  // Reference model: state is "what the memory holds", "what returns next cycle",
  // "how long IF has been refused" and "total refused cycles".
  logic [31:0] ref_mem [DEPTH];
  bit          pend_if, pend_dm, pend_err;
  logic [31:0] pend_if_d, pend_dm_d;
  int          m_wait, m_stall;

  always @(negedge clk) begin
    bit          e_if, e_dm, ok, e_en, e_we;
    logic [31:0] a, e_idx;
    if (rst) begin
      chk("rst_if_gnt", bus.if_gnt, 0);
      chk("rst_dm_gnt", bus.dm_gnt, 0);
      chk("rst_mem_en", bus.mem_en, 0);
      chk("rst_if_rvalid", bus.if_rvalid, 0);
      chk("rst_dm_rvalid", bus.dm_rvalid, 0);
      chk("rst_dm_err", bus.dm_err, 0);
      chk("rst_stall", bus.if_stall_cnt, 0);
      pend_if = 0; pend_dm = 0; pend_err = 0;
      pend_if_d = 0; pend_dm_d = 0;
      m_wait = 0; m_stall = 0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h1000_0000 + i;
    end else begin
      chk("if_rvalid", bus.if_rvalid, pend_if);
      chk("if_rdata", bus.if_rdata, pend_if ? pend_if_d : 32'h0);
      chk("dm_rvalid", bus.dm_rvalid, pend_dm);
      chk("dm_err", bus.dm_err, pend_dm && pend_err);
      chk("dm_rdata", bus.dm_rdata, pend_dm ? pend_dm_d : 32'h0);
      chk("stall_cnt", bus.if_stall_cnt, m_stall);

      e_if = bus.if_req && (!bus.dm_req || m_wait == MAX_WAIT);
      e_dm = bus.dm_req && !e_if;
      chk("if_gnt", bus.if_gnt, e_if);
      chk("dm_gnt", bus.dm_gnt, e_dm);

      a    = e_dm ? bus.dm_addr : bus.if_addr;
      ok   = (e_if || e_dm) && legal(a);
      e_en = ok;
      e_we = ok && e_dm && bus.dm_we;
      e_idx = (a / 4) % DEPTH;
      chk("mem_en", bus.mem_en, e_en);
      if (e_en) begin
        chk("mem_idx", bus.mem_idx, e_idx);
        chk("mem_we", bus.mem_we, e_we);
      end
      if (e_we) chk("mem_wdata", bus.mem_wdata, bus.dm_wdata);

      pend_if   = e_if;
      pend_if_d = ok ? ref_mem[e_idx] : 32'h0;
      pend_dm   = e_dm && !e_we;
      pend_err  = e_dm && !ok;
      pend_dm_d = ok ? ref_mem[e_idx] : 32'h0;
      if (e_we) ref_mem[e_idx] = bus.dm_wdata;

      if (bus.if_req && !e_if) begin
        if (m_wait < MAX_WAIT) m_wait++;
        if (m_stall < (1 << CNT_W) - 1) m_stall++;
      end else begin
        m_wait = 0;
      end
    end
  end

  task automatic drive(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                       input logic [31:0] da, input logic [31:0] dd);
    bus.if_req   = ir;
    bus.if_addr  = ia;
    bus.dm_req   = dr;
    bus.dm_we    = dw;
    bus.dm_addr  = da;
    bus.dm_wdata = dd;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    rst  = 1'b1;
    drive(1, 32'h0, 1, 0, 32'h4, 32'h0);

    // Requests during reset must not be granted.
    @(negedge clk);
    chk("reset_if_gnt", bus.if_gnt, 0);
    chk("reset_mem_en", bus.mem_en, 0);
    chk("reset_stall", bus.if_stall_cnt, 0);
    next();
    rst = 1'b0;

    // Fetch stream 0x0, 0x4, 0x8.
    drive(1, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk); chk("f0_gnt", bus.if_gnt, 1);
    next(); drive(1, 32'h4, 0, 0, 32'h0, 32'h0);
    @(negedge clk); chk("f0_rvalid", bus.if_rvalid, 1); chk("f0_rdata", bus.if_rdata, 32'h1000_0000);
    next(); drive(1, 32'h8, 0, 0, 32'h0, 32'h0);
    @(negedge clk); chk("f1_rdata", bus.if_rdata, 32'h1000_0001);
    next(); drive(0, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk); chk("f2_rdata", bus.if_rdata, 32'h1000_0002);

    // Store then load of 0x104.
    next(); drive(0, 32'h0, 1, 1, 32'h104, 32'hDEAD_BEEF);
    @(negedge clk); chk("st_we", bus.mem_we, 1); chk("st_idx", bus.mem_idx, 32'h41);
    next(); drive(0, 32'h0, 1, 0, 32'h104, 32'h0);
    @(negedge clk); chk("st_no_rvalid", bus.dm_rvalid, 0);
    next(); drive(0, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk); chk("ld_rvalid", bus.dm_rvalid, 1); chk("ld_rdata", bus.dm_rdata, 32'hDEAD_BEEF);

    // Continuous contention: DM four times, then IF.
    for (int k = 0; k < 10; k++) begin
      next(); drive(1, 32'h8, 1, 0, 32'h104, 32'h0);
      @(negedge clk);
      chk("arb_if_gnt", bus.if_gnt, (k % 5) == 4);
      if (k == 5) chk("arb_stall4", bus.if_stall_cnt, 4);
    end

    // Illegal accesses: misaligned load, out-of-range store, out-of-range fetch.
    next(); drive(0, 32'h0, 1, 0, 32'h102, 32'h0);
    @(negedge clk); chk("bad_ld_gnt", bus.dm_gnt, 1); chk("bad_ld_en", bus.mem_en, 0);
    next(); drive(0, 32'h0, 1, 1, 32'h1000, 32'h1234_5678);
    @(negedge clk);
    chk("bad_ld_err", bus.dm_err, 1); chk("bad_ld_rdata", bus.dm_rdata, 32'h0);
    chk("bad_st_en", bus.mem_en, 0);
    next(); drive(1, 32'h2000, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    chk("bad_st_err", bus.dm_err, 1); chk("bad_st_rvalid", bus.dm_rvalid, 1);
    chk("bad_if_gnt", bus.if_gnt, 1); chk("bad_if_en", bus.mem_en, 0);
    next(); drive(0, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    chk("bad_if_rvalid", bus.if_rvalid, 1); chk("bad_if_nop", bus.if_rdata, 32'h0);
    chk("mem0_kept", mem[0], 32'h1000_0000); chk("mem40_kept", mem[32'h40], 32'h1000_0040);

    // Reset right after a fetch grant drops that return.
    next(); drive(1, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk); chk("pre_rst_gnt", bus.if_gnt, 1);
    next(); rst = 1'b1; drive(0, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk); chk("rst_drop_rvalid", bus.if_rvalid, 0);
    next(); rst = 1'b0; drive(1, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk); chk("post_rst_gnt", bus.if_gnt, 1); chk("post_rst_norv", bus.if_rvalid, 0);
    next(); drive(0, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk); chk("post_rst_rdata", bus.if_rdata, 32'h1000_0000);

    next();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
